// File: rtl/logic16_arbiter.sv
// Four-way round-robin arbiter in front of one shared 16-bit bitwise logic unit.
// The single result slot is held until the consumer takes it.

// Gate-level bitwise unit (NOT a / AND / OR / XOR); the opcode selects one of the four gate outputs.
module logic16_gates #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] not_s;
    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        not u_not (not_s[i], a[i]);
        and u_and (and_s[i], a[i], b[i]);
        or  u_or  (or_s[i],  a[i], b[i]);
        xor u_xor (xor_s[i], a[i], b[i]);
    end

    // Opcode select of the gate outputs
    always_comb begin
        case (op)
            2'b00:   y = not_s;
            2'b01:   y = and_s;
            2'b10:   y = or_s;
            2'b11:   y = xor_s;
            default: y = '0;
        endcase
    end

endmodule

module logic16_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       prio_r;
    logic [1:0]       rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;

    logic [1:0]       winner_s;
    logic             any_s;
    logic             can_accept_s;
    logic             xfer_s;
    logic [1:0]       op_sel_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;
    logic [WIDTH-1:0] result_s;

    // Round-robin scan starting at prio; the 2-bit sum wraps modulo 4
    always_comb begin
        winner_s = 2'd0;
        any_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_s && req_valid[prio_r + 2'(k)]) begin
                winner_s = prio_r + 2'(k);
                any_s    = 1'b1;
            end else begin
                any_s    = any_s;
            end
        end
    end

    assign can_accept_s = (state_r == ST_EMPTY) || rsp_ready;
    assign xfer_s       = any_s && can_accept_s && !reset;

    assign op_sel_s = req_op[32'(winner_s) * 2 +: 2];
    assign a_sel_s  = req_a[32'(winner_s) * WIDTH +: WIDTH];
    assign b_sel_s  = req_b[32'(winner_s) * WIDTH +: WIDTH];

    logic16_gates #(
        .WIDTH (WIDTH)
    ) u_gates (
        .a  (a_sel_s),
        .b  (b_sel_s),
        .op (op_sel_s),
        .y  (result_s)
    );

    // Slot state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Slot next-state logic: a grant always fills, an accept without a grant empties
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_next_s = ST_FULL;
                end else if (rsp_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Grant output: one-hot on the winner only when the slot can take a result
    always_comb begin
        req_ready = '0;
        if (xfer_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Result slot and priority pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_r     <= 2'd0;
            rsp_id_r   <= 2'd0;
            rsp_data_r <= '0;
        end else if (xfer_s) begin
            prio_r     <= winner_s + 2'd1;
            rsp_id_r   <= winner_s;
            rsp_data_r <= result_s;
        end else begin
            prio_r     <= prio_r;
            rsp_id_r   <= rsp_id_r;
            rsp_data_r <= rsp_data_r;
        end
    end

    assign rsp_valid = (state_r == ST_FULL);
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed and randomized checks of logic16_arbiter against a transaction-level model.
module tb_logic16_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ready;

    int          n_vec = 0;
    int          n_err = 0;

    bit          m_valid = 1'b0;
    int          m_id    = 0;
    logic [15:0] m_data  = 16'h0000;
    int          m_prio  = 0;
    int          wait_cnt [4];
    logic [3:0]  last_xfer;

    always #5 clock = ~clock;

    logic16_arbiter #(
        .WIDTH (16),
        .NREQ  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check the grant before the edge, advance the model, check the slot after it.
    task automatic cycle();
        int         w;
        int         worst;
        bit         can;
        logic [3:0] exp_ready;
        #1;
        w         = -1;
        exp_ready = 4'b0000;
        can       = !m_valid || rsp_ready;
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_prio + k) % 4;
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        if (w >= 0 && can) exp_ready[w] = 1'b1;
        check("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
        @(posedge clock);
        last_xfer = exp_ready;
        for (int i = 0; i < 4; i++) if (!req_valid[i]) wait_cnt[i] = 0;
        if (reset) begin
            m_valid = 1'b0;
            m_id    = 0;
            m_data  = 16'h0000;
            m_prio  = 0;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else if (exp_ready != 4'b0000) begin
            m_data = ref_op(req_op[2*w +: 2], req_a[16*w +: 16], req_b[16*w +: 16]);
            for (int i = 0; i < 4; i++) if (i != w && req_valid[i]) wait_cnt[i]++;
            wait_cnt[w] = 0;
            m_id    = w;
            m_valid = 1'b1;
            m_prio  = (w + 1) % 4;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
        check("rsp_id", {30'h0, rsp_id}, m_id);
        check("rsp_data", {16'h0, rsp_data}, {16'h0, m_data});
        worst = 0;
        for (int i = 0; i < 4; i++) if (wait_cnt[i] > worst) worst = wait_cnt[i];
        check("fairness_bound", (worst <= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int          rr_exp [6];
        logic [15:0] t2_exp [4];
        logic [15:0] hold_data;
        rr_exp = '{0, 1, 2, 3, 0, 1};
        t2_exp = '{16'hC33C, 16'h3CC3, 16'hFFFF, 16'hC33C};
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        // Reset
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_op    = 8'h00;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        check("rst_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_data", {16'h0, rsp_data}, 32'h0000);

        // Single AND on requester 0
        reset          = 1'b0;
        req_valid      = 4'b0001;
        req_op[1:0]    = 2'b01;
        req_a[15:0]    = 16'hF0F0;
        req_b[15:0]    = 16'hFF00;
        cycle();
        check("t1_data", {16'h0, rsp_data}, 32'h0000F000);
        check("t1_id", {30'h0, rsp_id}, 32'd0);
        req_valid = 4'b0000;
        cycle();
        check("t1_drain", {31'h0, rsp_valid}, 32'd0);

        // All four ops back to back on requester 2
        req_valid     = 4'b0100;
        req_a[47:32]  = 16'b0011110011000011;
        req_b[47:32]  = 16'hFFFF;
        for (int j = 0; j < 4; j++) begin
            req_op[5:4] = 2'(j);
            cycle();
            check("t2_data", {16'h0, rsp_data}, {16'h0, t2_exp[j]});
            check("t2_id", {30'h0, rsp_id}, 32'd2);
        end
        req_valid = 4'b0000;
        cycle();

        // Round-robin from reset with all requesters active
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_op    = 8'b11_10_01_00;
        req_a     = 64'h1234_5678_9ABC_DEF0;
        req_b     = 64'h0F0F_F0F0_00FF_FF00;
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("rr_id", {30'h0, rsp_id}, rr_exp[j]);
        end

        // Backpressure holds the slot and blocks grants
        rsp_ready = 1'b0;
        hold_data = m_data;
        for (int j = 0; j < 3; j++) begin
            cycle();
            check("bp_ready", {28'h0, req_ready}, 32'd0);
            check("bp_id", {30'h0, rsp_id}, 32'd1);
            check("bp_data", {16'h0, rsp_data}, {16'h0, hold_data});
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_next_id", {30'h0, rsp_id}, 32'd2);

        // Reset mid-stream discards the result and restarts priority at 0
        reset = 1'b1;
        cycle();
        check("mr_valid", {31'h0, rsp_valid}, 32'd0);
        check("mr_data", {16'h0, rsp_data}, 32'd0);
        reset     = 1'b0;
        req_valid = 4'b0110;
        cycle();
        check("mr_first_id", {30'h0, rsp_id}, 32'd1);

        // Sparse requests and idle
        req_valid = 4'b1000;
        cycle();
        check("sp_id3", {30'h0, rsp_id}, 32'd3);
        req_valid = 4'b0100;
        cycle();
        check("sp_id2", {30'h0, rsp_id}, 32'd2);
        req_valid = 4'b0000;
        cycle();
        check("sp_idle", {31'h0, rsp_valid}, 32'd0);
        cycle();
        check("sp_idle2", {31'h0, rsp_valid}, 32'd0);

        // Randomized traffic obeying the hold-until-transfer rule
        last_xfer = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || last_xfer[i]) begin
                    req_valid[i]       = ($urandom_range(0, 2) != 0);
                    req_op[2*i +: 2]   = 2'($urandom);
                    req_a[16*i +: 16]  = 16'($urandom);
                    req_b[16*i +: 16]  = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
